// File: rtl/uart_pkg.sv
// Shared types and constants for the UART autobaud measurement block.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_MEASURE,
    ST_CALC
  } state_t;

  localparam logic [7:0] SYNC_CHAR = 8'h55;
  localparam int         MEAS_BITS = 8;

  // Falling edges seen on an idle-high line carrying one framed character
  // (start bit, data LSB first, stop bit).
  function automatic int sync_falls(input logic [7:0] ch);
    logic [9:0] frame;
    logic       prev;
    int         n;
    frame = {1'b1, ch, 1'b0};
    prev  = 1'b1;
    n     = 0;
    for (int i = 0; i < 10; i++) begin
      if (prev && !frame[i]) n++;
      prev = frame[i];
    end
    return n;
  endfunction

  localparam int SYNC_FALLS = sync_falls(SYNC_CHAR);

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for the raw rx line plus rise/fall detection on the
// synchronized level. All flops reset high so an idle line gives no edge.
module sync_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;

  // Shift the line through the synchronizer and one history stage.
  always_comb begin
    s1_d   = d_i;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  // Synchronizer and history registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign rise_o = s2_q & ~prev_q;
  assign fall_o = ~s2_q & prev_q;

endmodule

// File: rtl/uart_autobaud.sv
// Measures the bit period of a 0x55 sync character and produces a baud divider.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for start_i; divider outputs hold last lock
// ST_ARMED   | waiting for the first falling edge (start bit)
// ST_MEASURE | timing falling-edge intervals, checking runs/deviation/timeout
// ST_CALC    | one cycle: divide T8 by MEAS_BITS with rounding, pulse done
module uart_autobaud
  import uart_pkg::*;
#(
  parameter int MIN_BIT_CYC = 4,
  parameter int TIMEOUT_CYC = 2**24
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic [31:0] baud_div_o,
  output logic        baud_valid_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int INT_W     = $clog2(TIMEOUT_CYC + 1);
  localparam int RUN_W     = $clog2(MIN_BIT_CYC + 1);
  localparam int TOT_W     = 35;
  localparam int FC_W      = 3;
  localparam int DIV_SHIFT = $clog2(MEAS_BITS);
  // Value of the falls-after-first counter when the last sync edge arrives.
  localparam int LAST_FALL = SYNC_FALLS - 2;

  state_t             state_q, state_d;
  logic [TOT_W-1:0]   tot_q, tot_d;
  logic [INT_W-1:0]   int_q, int_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [INT_W-1:0]   i1_q, i1_d;
  logic [FC_W-1:0]    fcnt_q, fcnt_d;
  logic [TOT_W-1:0]   t8_q, t8_d;
  logic [31:0]        div_q, div_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               rise, fall;
  logic [INT_W-1:0]   int_now;
  logic [RUN_W-1:0]   run_now;
  logic [TOT_W-1:0]   tot_now;
  logic [INT_W-1:0]   dev;
  logic               err_now;

  sync_edge_det u_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (rx_i),
    .rise_o (rise),
    .fall_o (fall)
  );

  // Counter values including the current cycle; the run counter saturates
  // once the run is long enough to be legal.
  assign int_now = int_q + INT_W'(1);
  assign tot_now = tot_q + TOT_W'(1);
  assign run_now = (run_q == RUN_W'(MIN_BIT_CYC)) ? run_q : run_q + RUN_W'(1);
  assign dev     = (int_now > i1_q) ? (int_now - i1_q) : (i1_q - int_now);

  // Next-state, counter and output logic.
  always_comb begin
    state_d = state_q;
    tot_d   = tot_q;
    int_d   = int_q;
    run_d   = run_q;
    i1_d    = i1_q;
    fcnt_d  = fcnt_q;
    t8_d    = t8_q;
    div_d   = div_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    err_now = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_ARMED;
      end

      ST_ARMED: begin
        if (fall) begin
          state_d = ST_MEASURE;
          tot_d   = '0;
          int_d   = '0;
          run_d   = '0;
          fcnt_d  = '0;
        end
      end

      ST_MEASURE: begin
        tot_d   = tot_now;
        int_d   = int_now;
        run_d   = run_now;
        err_now = (int_now == INT_W'(TIMEOUT_CYC)) || (&tot_q) ||
                  ((rise || fall) && (run_now < RUN_W'(MIN_BIT_CYC)));
        if (rise || fall) run_d = '0;
        if (fall) begin
          int_d  = '0;
          fcnt_d = fcnt_q + FC_W'(1);
          if (fcnt_q == '0) i1_d = int_now;
          else if (dev > (i1_q >> 2)) err_now = 1'b1;
        end
        if (err_now) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (fall && (fcnt_q == FC_W'(LAST_FALL))) begin
          t8_d    = tot_now;
          state_d = ST_CALC;
        end
      end

      ST_CALC: begin
        div_d   = 32'((({1'b0, t8_q} + 36'(MEAS_BITS / 2)) >> DIV_SHIFT) - 36'd1);
        valid_d = 1'b1;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Counters, captured intervals and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tot_q   <= '0;
      int_q   <= '0;
      run_q   <= '0;
      i1_q    <= '0;
      fcnt_q  <= '0;
      t8_q    <= '0;
      div_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      tot_q   <= tot_d;
      int_q   <= int_d;
      run_q   <= run_d;
      i1_q    <= i1_d;
      fcnt_q  <= fcnt_d;
      t8_q    <= t8_d;
      div_q   <= div_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy_o       = (state_q != ST_IDLE);
  assign baud_div_o   = div_q;
  assign baud_valid_o = valid_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_uart_autobaud.sv
// Bench for uart_autobaud: timestamp-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_uart_autobaud;

  localparam int MIN_BIT = 4;
  localparam int TO      = 1000;
  localparam int MAXC    = 200000;
  localparam int MI = 0, MA = 1, MM = 2, MC = 3;

  logic        clk_i = 1'b0;
  logic        rst_i, rx_i, start_i;
  logic        busy_o;
  logic [31:0] baud_div_o;
  logic        baud_valid_o, done_o, err_o;

  always #5 clk_i = ~clk_i;

  uart_autobaud #(.MIN_BIT_CYC(MIN_BIT), .TIMEOUT_CYC(TO)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .rx_i         (rx_i),
    .start_i      (start_i),
    .busy_o       (busy_o),
    .baud_div_o   (baud_div_o),
    .baud_valid_o (baud_valid_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model state ----------------
  int     cyc = 0;
  bit     xs [0:MAXC-1];
  bit     model_ready = 0;
  int     m_mode = MI;
  longint m_t_first, m_t_fall, m_t_edge, m_i1, m_t8;
  int     m_nfall;
  longint exp_div = 0;
  bit     exp_valid = 0, exp_busy = 0, exp_done = 0, exp_err = 0;
  int     n_done = 0, n_err = 0;
  longint last_err_cyc = -1;

  // Per-cycle compare against the model, then advance the model using the
  // inputs held during this cycle.
  always @(negedge clk_i) begin
    bit     f, r, bad, nd, ne;
    longint interval, run, dv;
    if (cyc < MAXC) xs[cyc] = rx_i;
    if (model_ready) begin
      check("busy", busy_o, exp_busy);
      check("div", baud_div_o, exp_div);
      check("valid", baud_valid_o, exp_valid);
      check("done", done_o, exp_done);
      check("err", err_o, exp_err);
      check("done_err_excl", done_o & err_o, 0);
    end
    if (done_o === 1'b1) n_done++;
    if (err_o === 1'b1) begin n_err++; last_err_cyc = cyc; end

    // Synchronized line level in cycle c is the raw level of cycle c-2.
    f  = (cyc >= 3) && xs[cyc-3] && !xs[cyc-2];
    r  = (cyc >= 3) && !xs[cyc-3] && xs[cyc-2];
    nd = 0;
    ne = 0;
    if (rst_i === 1'b1) begin
      m_mode    = MI;
      exp_div   = 0;
      exp_valid = 0;
      for (int k = 0; k < 3; k++) if (cyc - k >= 0 && cyc - k < MAXC) xs[cyc-k] = 1'b1;
      model_ready = 1;
    end else begin
      case (m_mode)
        MI: if (start_i === 1'b1) m_mode = MA;
        MA: if (f) begin
          m_mode    = MM;
          m_t_first = cyc;
          m_t_fall  = cyc;
          m_t_edge  = cyc;
          m_nfall   = 1;
        end
        MM: begin
          interval = cyc - m_t_fall;
          run      = cyc - m_t_edge;
          bad      = (interval >= TO);
          if ((f || r) && run < MIN_BIT) bad = 1;
          if (f) begin
            if (m_nfall + 1 == 2) m_i1 = interval;
            else begin
              dv = interval - m_i1;
              if (dv < 0) dv = -dv;
              if (dv > m_i1 / 4) bad = 1;
            end
          end
          if (bad) begin
            ne     = 1;
            m_mode = MI;
          end else begin
            if (f) begin m_nfall++; m_t_fall = cyc; end
            if (f || r) m_t_edge = cyc;
            if (f && m_nfall == 5) begin
              m_t8   = cyc - m_t_first;
              m_mode = MC;
            end
          end
        end
        default: begin
          exp_div   = (m_t8 + 4) / 8 - 1;
          exp_valid = 1;
          nd        = 1;
          m_mode    = MI;
        end
      endcase
    end
    exp_done = nd;
    exp_err  = ne;
    exp_busy = (m_mode != MI);
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  bit lv[$];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic add(input bit v, input int n);
    for (int i = 0; i < n; i++) lv.push_back(v);
  endtask

  task automatic add_byte(input logic [7:0] b, input int bl);
    add(1'b0, bl);
    for (int i = 0; i < 8; i++) add(b[i], bl);
    add(1'b1, bl);
  endtask

  task automatic play(input int start_at, input int rst_at, input int rst_len, input bit rnd);
    for (int i = 0; i < lv.size(); i++) begin
      rx_i    = lv[i];
      start_i = (i == start_at) || (rnd && $urandom_range(0, 31) == 0);
      rst_i   = (i >= rst_at) && (i < rst_at + rst_len);
      tick();
    end
    start_i = 1'b0;
    rst_i   = 1'b0;
    rx_i    = 1'b1;
    lv.delete();
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (busy_o !== 1'b0 && n < bound) begin tick(); n++; end
    check("idle_wait", busy_o, 0);
    repeat (3) tick();
  endtask

  task automatic lock_55(input int bl);
    add(1'b1, 4);
    add_byte(8'h55, bl);
    add(1'b1, 10);
    play(0, -1, 0, 0);
    wait_idle(4000);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0, c0, dlow, half;
    logic [7:0] got;
    logic       sb;
    int ty, bl, pre, st, ra, rl, gj, a, g, n;
    logic [7:0] ch;
    logic [9:0] fr;

    rst_i = 1'b1; rx_i = 1'b1; start_i = 1'b0;
    repeat (4) tick();
    rst_i = 1'b0;
    tick();
    check("rst_busy", busy_o, 0);
    check("rst_div", baud_div_o, 0);
    check("rst_valid", baud_valid_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);

    // 115200 baud at 50 MHz: 434 cycles per bit.
    d0 = n_done; e0 = n_err;
    lock_55(434);
    check("b434_t8_model", m_t8, 3472);
    check("b434_div", baud_div_o, 433);
    check("b434_valid", baud_valid_o, 1);
    check("b434_done_cnt", n_done - d0, 1);
    check("b434_err_cnt", n_err - e0, 0);

    // 16 cycles per bit, then receive 0xA3 with a divider-timed sampler.
    lock_55(16);
    check("b16_div", baud_div_o, 15);
    check("b16_valid", baud_valid_o, 1);
    add(1'b1, 3);
    add_byte(8'hA3, 16);
    add(1'b1, 8);
    got = 8'h00; sb = 1'b1;
    fork
      play(-1, -1, 0, 0);
      begin
        n = 0;
        while (rx_i !== 1'b0 && n < 200) begin @(negedge clk_i); n++; end
        half = (baud_div_o + 1) / 2;
        repeat (half) @(negedge clk_i);
        sb = rx_i;
        for (int i = 0; i < 8; i++) begin
          repeat (baud_div_o + 1) @(negedge clk_i);
          got[i] = rx_i;
        end
      end
    join
    check("loop_start_bit", sb, 0);
    check("loop_rx_byte", got, 8'hA3);

    // Short low glitch after arming.
    d0 = n_done; e0 = n_err;
    add(1'b1, 5); add(1'b0, 2); add(1'b1, 40);
    play(0, -1, 0, 0);
    wait_idle(2000);
    check("glitch_err_cnt", n_err - e0, 1);
    check("glitch_done_cnt", n_done - d0, 0);
    check("glitch_div", baud_div_o, 15);
    check("glitch_valid", baud_valid_o, 1);

    // 0x00: only one falling edge, so the interval timer expires.
    e0 = n_err;
    c0 = cyc;
    add(1'b1, 3);
    dlow = c0 + 3;
    add_byte(8'h00, 16);
    add(1'b1, 10);
    play(0, -1, 0, 0);
    wait_idle(2000);
    check("timeout_err_cnt", n_err - e0, 1);
    check("timeout_latency", last_err_cyc - dlow, 1003);
    check("timeout_busy", busy_o, 0);
    check("timeout_div", baud_div_o, 15);

    // Second bit pair stretched to 48 cycles.
    d0 = n_done; e0 = n_err;
    add(1'b1, 4);
    add(1'b0, 16); add(1'b1, 16);
    add(1'b0, 16); add(1'b1, 32);
    for (int i = 0; i < 3; i++) begin add(1'b0, 16); add(1'b1, 16); end
    add(1'b1, 10);
    play(0, -1, 0, 0);
    wait_idle(2000);
    check("dev_err_cnt", n_err - e0, 1);
    check("dev_done_cnt", n_done - d0, 0);
    check("dev_valid", baud_valid_o, 1);

    // Reset in the middle of a measurement.
    d0 = n_done; e0 = n_err;
    add(1'b1, 3); add(1'b0, 16); add(1'b1, 16); add(1'b0, 5);
    play(0, -1, 0, 0);
    rst_i = 1'b1;
    tick();
    check("mrst_busy", busy_o, 0);
    check("mrst_div", baud_div_o, 0);
    check("mrst_valid", baud_valid_o, 0);
    check("mrst_done", done_o, 0);
    check("mrst_err", err_o, 0);
    rst_i = 1'b0;
    rx_i  = 1'b1;
    repeat (20) tick();
    check("mrst_pulses", (n_done - d0) + (n_err - e0), 0);
    lock_55(16);
    check("mrst_relock_div", baud_div_o, 15);
    check("mrst_relock_valid", baud_valid_o, 1);

    // Random traffic checked by the per-cycle model.
    for (int it = 0; it < 30; it++) begin
      ty  = $urandom_range(0, 4);
      bl  = $urandom_range(4, 30);
      pre = $urandom_range(1, 6);
      st  = $urandom_range(0, pre + 3);
      ch  = 8'h55;
      ra  = -1;
      rl  = 0;
      add(1'b1, pre);
      case (ty)
        0: add_byte(8'h55, bl);
        1: begin ch = 8'($urandom_range(0, 255)); add_byte(ch, bl); end
        2: begin
          add(1'b0, bl + $urandom_range(0, 4) - 2);
          for (int i = 0; i < 8; i++) add(ch[i], bl + $urandom_range(0, 4) - 2);
          add(1'b1, bl);
        end
        3: begin
          fr = {1'b1, ch, 1'b0};
          gj = $urandom_range(0, 9);
          for (int j = 0; j < 10; j++) begin
            if (j == gj) begin
              a = $urandom_range(1, bl - 3);
              g = $urandom_range(1, 3);
              add(fr[j], a);
              add(!fr[j], g);
              add(fr[j], bl - a - g);
            end else begin
              add(fr[j], bl);
            end
          end
        end
        default: begin
          add_byte(8'h55, bl);
          ra = pre + $urandom_range(0, 8 * bl);
          rl = $urandom_range(1, 3);
        end
      endcase
      add(1'b1, $urandom_range(2, 20));
      play(st, ra, rl, (it % 3) == 0);
      n = 0;
      while (busy_o === 1'b1 && n < 1500) begin tick(); n++; end
      if (busy_o === 1'b1) begin rst_i = 1'b1; tick(); rst_i = 1'b0; end
      repeat (3) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_autobaud.md
UART_AUTOBAUD -- requirements
Module: uart_autobaud

Interface
REQ-001 SHALL have parameter MIN_BIT_CYC, default 4: minimum legal line-level run, in clk_i cycles.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 2**24: maximum cycles between consecutive falling edges during measurement.
REQ-003 SHALL have port clk_i  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port rx_i  in  1  raw asynchronous UART line, idle high.
REQ-006 SHALL have port start_i  in  1  one-cycle request to arm a measurement.
REQ-007 SHALL have port busy_o  out  1  high whenever state is not IDLE.
REQ-008 SHALL have port baud_div_o  out  32  divider for uart_rx/uart_tx; bit period = baud_div_o+1 cycles.
REQ-009 SHALL have port baud_valid_o  out  1  baud_div_o holds a successful measurement.
REQ-010 SHALL have port done_o  out  1  one-cycle pulse on successful lock.
REQ-011 SHALL have port err_o  out  1  one-cycle pulse on failed measurement.

Function
REQ-012 SHALL pass rx_i through a 2-FF synchronizer and detect edges on the synchronized signal only.
REQ-013 SHALL implement states IDLE, ARMED, MEASURE, CALC.
REQ-014 IDLE: start_i -> ARMED next cycle; start_i outside IDLE SHALL be ignored.
REQ-015 ARMED: first synchronized falling edge -> MEASURE; total counter and interval counter cleared to 0 in that cycle.
REQ-016 MEASURE: expects sync char 0x55 (LSB first, 5 falling edges at bit times 0,2,4,6,8); counters increment every cycle.
REQ-017 At each falling edge 2..5 the interval counter SHALL be captured then cleared; interval 1 is stored as reference I1.
REQ-018 Intervals 2..4 SHALL satisfy |Ik - I1| <= I1>>2; otherwise error.
REQ-019 Any edge (either polarity) ending a level run shorter than MIN_BIT_CYC cycles SHALL be an error.
REQ-020 Interval counter reaching TIMEOUT_CYC SHALL be an error.
REQ-021 Total counter SHALL be 35 bits; saturation SHALL be an error.
REQ-022 5th falling edge -> CALC; T8 = total count at that edge.
REQ-023 CALC (one cycle): baud_div_o <= ((T8+4)>>3) - 1, baud_valid_o <= 1, done_o pulses, -> IDLE.
REQ-024 Error in any MEASURE cycle: err_o pulses, -> IDLE; baud_div_o and baud_valid_o retain their previous values.
REQ-025 baud_div_o and baud_valid_o SHALL change only in CALC or on reset; a new start_i SHALL NOT clear them.
REQ-026 When start_i coincides with a falling edge in IDLE, that edge SHALL be ignored.
REQ-027 When an error condition and the 5th edge coincide, error SHALL win.
REQ-028 done_o and err_o SHALL never be high in the same cycle.

Reset
REQ-029 rst_i SHALL force state IDLE, all counters to 0, and synchronizer flops to 1 (no spurious edge).
REQ-030 rst_i SHALL clear outputs: busy_o=0, baud_div_o=0, baud_valid_o=0, done_o=0, err_o=0.
REQ-031 rst_i asserted mid-MEASURE SHALL abort the measurement with no done_o/err_o pulse.

Structure
REQ-032 Package uart_pkg SHALL hold the autobaud state_t enum, SYNC_CHAR=8'h55 and MEAS_BITS=8.
REQ-033 The synchronizer plus rise/fall edge detector SHALL be one sub-module, sync_edge_det, with synchronous active-high reset.
REQ-034 FSM, counters and divider arithmetic SHALL reside in uart_autobaud.

Verification
REQ-035 Bit=434 cycles (115200 @ 50 MHz), send 0x55 -> T8=3472, baud_div_o=433, baud_valid_o=1, one done_o pulse.
REQ-036 Bit=16 cycles, send 0x55 -> baud_div_o=15; then loop to a uart_rx using it receives 0xA3 correctly.
REQ-037 After lock at 15, start, inject 2-cycle low glitch -> err_o pulse, baud_div_o stays 15, baud_valid_o stays 1.
REQ-038 TIMEOUT_CYC=1000, start, send 0x00 -> err_o exactly when interval counter hits 1000, state IDLE.
REQ-039 Bit=16, second bit pair stretched to 48 cycles -> deviation error, err_o pulse, no done_o.
REQ-040 rst_i during MEASURE -> all outputs 0 next cycle; subsequent start + 0x55 at bit=16 -> baud_div_o=15.
